tv80_io_mailbox: RTL

TV80_IO_MAILBOX -- requirements
Module: tv80_io_mailbox

---
 rtl/tv80_io_mailbox.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/tv80_io_mailbox.sv
// tv80_io_mailbox: TV80 I/O-mapped mailbox with a 4-entry RX FIFO (host -> CPU),
// a TX holding register (CPU -> local), a scratch register and wait-state insertion.
// Optional feature macro: TV80_MAILBOX_INTACK_EN (maskable interrupt + IM2-style
// vector on interrupt acknowledge). Default build leaves it disabled.
module tv80_io_mailbox #(
  parameter logic [7:0]  IO_BASE     = 8'h40,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [7:0]  INT_VECTOR  = 8'hE0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_do,
  input  logic        m1_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        int_n,
  input  logic        host_wr_valid,
  input  logic [7:0]  host_wr_data,
  output logic        host_wr_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned DW    = 8;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WCW   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_DATA    = 2'd0;
  localparam logic [1:0] SEL_STATUS  = 2'd1;
  localparam logic [1:0] SEL_SCRATCH = 2'd2;
  localparam logic [1:0] SEL_COUNT   = 2'd3;

  state_e          state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            wait_n_q;
  logic            blocked_q;
  logic [DW-1:0]   rx_mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            tx_valid_q;
  logic [DW-1:0]   tx_data_q;
  logic [DW-1:0]   scratch_q;
  logic            ie_c;

  logic            strobe_c, acc_c, rd_acc_c, wr_acc_c, fire_c;
  logic [1:0]      sel_c;
  logic            rx_full_c, rx_nonempty_c;
  logic            push_c, pop_c, tx_load_c, scratch_wr_c, ie_wr_c;
  logic            unused_addr_hi;

  // Bus decode; the upper address byte carries no meaning for this block
  assign unused_addr_hi = ^A[15:8];
  assign strobe_c = ~iorq_n & (~rd_n | ~wr_n);
  assign acc_c    = ~iorq_n & m1_n & (~rd_n ^ ~wr_n) & (A[7:2] == IO_BASE[7:2]);
  assign rd_acc_c = acc_c & ~rd_n;
  assign wr_acc_c = acc_c & ~wr_n;
  assign sel_c    = A[1:0];

  assign rx_full_c     = (count_q == CW'(DEPTH));
  assign rx_nonempty_c = (count_q != CW'(0));
  assign host_wr_ready = reset_n & ~rx_full_c;

  // Side effects fire on the single cycle that transitions into DONE
  assign push_c       = host_wr_valid & host_wr_ready;
  assign pop_c        = fire_c & rd_acc_c & (sel_c == SEL_DATA) & rx_nonempty_c;
  assign tx_load_c    = fire_c & wr_acc_c & (sel_c == SEL_DATA) & ~tx_valid_q;
  assign scratch_wr_c = fire_c & wr_acc_c & (sel_c == SEL_SCRATCH);
  assign ie_wr_c      = fire_c & wr_acc_c & (sel_c == SEL_STATUS);

  // Access FSM next-state, wait counter and side-effect strobe
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fire_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_c && !blocked_q) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
            fire_c  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = '0;
          end
        end
      end
      ST_WAIT: begin
        if (!acc_c) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == WCW'(WAIT_CYCLES - 1)) begin
          state_d = ST_DONE;
          fire_c  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      ST_DONE: begin
        if (!strobe_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, registered wait_n and post-reset strobe lockout
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      wait_n_q  <= 1'b1;
      blocked_q <= strobe_c;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      wait_n_q <= (state_d != ST_WAIT);
      if (!strobe_c) blocked_q <= 1'b0;
    end
  end

  assign wait_n = wait_n_q;

  // RX FIFO occupancy next value
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // RX FIFO storage (no reset needed; pointers and count qualify contents)
  always_ff @(posedge clk) begin
    if (push_c) rx_mem_q[wr_ptr_q] <= host_wr_data;
  end

  // RX pointers/count, TX holding register and scratch
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      scratch_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (tx_valid_q && tx_ready) begin
        tx_valid_q <= 1'b0;
      end else if (tx_load_c) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= cpu_do;
      end
      if (scratch_wr_c) scratch_q <= cpu_do;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

`ifdef TV80_MAILBOX_INTACK_EN
  logic ie_q;
  logic int_n_q;

  // Interrupt enable and registered interrupt request
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ie_q    <= 1'b0;
      int_n_q <= 1'b1;
    end else begin
      if (ie_wr_c) ie_q <= cpu_do[0];
      int_n_q <= ~(ie_q & rx_nonempty_c);
    end
  end

  assign ie_c  = ie_q;
  assign int_n = int_n_q;
`else
  logic unused_ie_wr;
  assign unused_ie_wr = ie_wr_c;
  assign ie_c  = 1'b0;
  assign int_n = 1'b1;
`endif

  // CPU read data mux; idle bus reads as all ones
  always_comb begin
    di = 8'hFF;
    if (reset_n) begin
      if (rd_acc_c) begin
        case (sel_c)
          SEL_DATA:    di = rx_nonempty_c ? rx_mem_q[rd_ptr_q] : 8'h00;
          SEL_STATUS:  di = {4'b0000, ie_c, tx_valid_q, rx_full_c, rx_nonempty_c};
          SEL_SCRATCH: di = scratch_q;
          SEL_COUNT:   di = {5'b00000, count_q};
          default:     di = 8'hFF;
        endcase
      end
`ifdef TV80_MAILBOX_INTACK_EN
      if (!iorq_n && !m1_n) di = INT_VECTOR;
`endif
    end
  end

endmodule
